// File: rtl/t08_regfile_sequencer.sv
// Multi-cycle access controller for the t08 register file: reads the source
// operands, waits for writeback data, then issues a single write cycle.
module t08_regfile_sequencer #(
  parameter int READ_LAT   = 1,
  parameter int WB_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [4:0] req_rs1,
  input  logic [4:0] req_rs2,
  input  logic [4:0] req_rd,
  input  logic       req_use_rs1,
  input  logic       req_use_rs2,
  input  logic       req_wb_en,
  input  logic [1:0] req_wb_src,
  input  logic       wb_data_ready,
  input  logic       flush,
  output logic [4:0] address_r1,
  output logic [4:0] address_r2,
  output logic [4:0] address_rd,
  output logic       en_read_1,
  output logic       en_read_2,
  output logic       en_write,
  output logic [1:0] data_in_control,
  output logic       operands_valid,
  output logic       done,
  output logic       err,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, READ, WAIT_RES, WRITE} state_t;

  localparam logic [2:0] READ_LAST = 3'(READ_LAT - 1);
  localparam logic [7:0] TO_LAST   = 8'(WB_TIMEOUT - 1);

  state_t     state, state_next;
  logic [4:0] rs1_q, rs2_q, rd_q;
  logic       use_rs1_q, use_rs2_q, wb_en_q;
  logic [1:0] wb_src_q;
  logic [2:0] read_cnt;
  logic [7:0] wait_cnt;
  logic       done_q, err_q, done_next, err_next;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state     <= IDLE;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      use_rs1_q <= 1'b0;
      use_rs2_q <= 1'b0;
      wb_en_q   <= 1'b0;
      wb_src_q  <= '0;
      read_cnt  <= '0;
      wait_cnt  <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state  <= state_next;
      done_q <= done_next;
      err_q  <= err_next;
      if (state == IDLE && req_valid) begin
        rs1_q     <= req_rs1;
        rs2_q     <= req_rs2;
        rd_q      <= req_rd;
        use_rs1_q <= req_use_rs1;
        use_rs2_q <= req_use_rs2;
        wb_en_q   <= req_wb_en;
        wb_src_q  <= req_wb_src;
      end
      // Counters restart on every state change so each state times itself.
      if (state_next != state) begin
        read_cnt <= '0;
        wait_cnt <= '0;
      end else begin
        read_cnt <= read_cnt + 3'd1;
        if (wait_cnt != 8'hFF)
          wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    err_next   = 1'b0;
    case (state)
      IDLE:
        if (req_valid)
          state_next = READ;
      READ:
        if (flush)
          state_next = IDLE;
        else if (read_cnt == READ_LAST) begin
          if (wb_src_q == 2'd3) begin
            state_next = IDLE;
            err_next   = 1'b1;
          end else if (!wb_en_q || rd_q == 5'd0) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else if (wb_src_q == 2'd1)
            state_next = WRITE;
          else
            state_next = WAIT_RES;
        end
      // flush beats ready, and ready beats timeout expiry in the same cycle.
      WAIT_RES:
        if (flush)
          state_next = IDLE;
        else if (wb_data_ready)
          state_next = WRITE;
        else if (wait_cnt == TO_LAST) begin
          state_next = IDLE;
          err_next   = 1'b1;
        end
      WRITE:
        state_next = IDLE;
      default:
        state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready       = (state == IDLE);
    busy            = (state != IDLE);
    address_r1      = '0;
    address_r2      = '0;
    address_rd      = '0;
    en_read_1       = 1'b0;
    en_read_2       = 1'b0;
    en_write        = 1'b0;
    data_in_control = '0;
    operands_valid  = 1'b0;
    done            = done_q | (state == WRITE);
    err             = err_q;
    case (state)
      READ: begin
        address_r1     = rs1_q;
        address_r2     = rs2_q;
        en_read_1      = use_rs1_q;
        en_read_2      = use_rs2_q;
        operands_valid = (read_cnt == READ_LAST);
      end
      WAIT_RES: begin
        address_rd      = rd_q;
        data_in_control = wb_src_q;
      end
      WRITE: begin
        en_write        = 1'b1;
        address_rd      = rd_q;
        data_in_control = wb_src_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_t08_regfile_sequencer.sv
// Randomized bench for t08_regfile_sequencer; expected outputs come from a
// per-transaction timeline derived from the access rules.
module tb_t08_regfile_sequencer;

  localparam int RL = 2;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       nRst;
  logic       req_valid, req_ready;
  logic [4:0] req_rs1, req_rs2, req_rd;
  logic       req_use_rs1, req_use_rs2, req_wb_en;
  logic [1:0] req_wb_src;
  logic       wb_data_ready, flush;
  logic [4:0] address_r1, address_r2, address_rd;
  logic       en_read_1, en_read_2, en_write;
  logic [1:0] data_in_control;
  logic       operands_valid, done, err, busy;

  int   checks = 0;
  int   errors = 0;
  logic exp_done = 1'b0;
  logic exp_err  = 1'b0;

  t08_regfile_sequencer #(.READ_LAT(RL), .WB_TIMEOUT(TO)) dut (
    .clk(clk), .nRst(nRst), .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
    .req_use_rs1(req_use_rs1), .req_use_rs2(req_use_rs2),
    .req_wb_en(req_wb_en), .req_wb_src(req_wb_src),
    .wb_data_ready(wb_data_ready), .flush(flush),
    .address_r1(address_r1), .address_r2(address_r2), .address_rd(address_rd),
    .en_read_1(en_read_1), .en_read_2(en_read_2), .en_write(en_write),
    .data_in_control(data_in_control), .operands_valid(operands_valid),
    .done(done), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic checkIdle();
    checkOutput("idle_ready", 32'(req_ready), 32'd1);
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_rd_en", 32'({en_read_1, en_read_2, en_write, operands_valid}), 32'd0);
    checkOutput("idle_addr", 32'({address_r1, address_r2, address_rd, data_in_control}), 32'd0);
    checkOutput("idle_done", 32'(done), 32'(exp_done));
    checkOutput("idle_err", 32'(err), 32'(exp_err));
    exp_done = 1'b0;
    exp_err  = 1'b0;
  endtask

  task automatic randomJunk();
    req_valid     = 1'($urandom);
    req_rs1       = 5'($urandom);
    req_rs2       = 5'($urandom);
    req_rd        = 5'($urandom);
    req_use_rs1   = 1'($urandom);
    req_use_rs2   = 1'($urandom);
    req_wb_en     = 1'($urandom);
    req_wb_src    = 2'($urandom);
    wb_data_ready = 1'($urandom);
  endtask

  // Entered and left at a negedge with the DUT in IDLE; a delay >= TO never readies.
  task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                               input logic u1, input logic u2, input logic wen, input logic [1:0] src,
                               input int ready_delay, input int flush_read, input int flush_wait,
                               input logic flush_write);
    checkIdle();
    req_valid = 1'b1; req_rs1 = rs1; req_rs2 = rs2; req_rd = rd;
    req_use_rs1 = u1; req_use_rs2 = u2; req_wb_en = wen; req_wb_src = src;
    @(negedge clk);
    for (int i = 0; i < RL; i++) begin
      checkOutput("read_addr1", 32'(address_r1), 32'(rs1));
      checkOutput("read_addr2", 32'(address_r2), 32'(rs2));
      checkOutput("read_en", 32'({en_read_1, en_read_2}), 32'({u1, u2}));
      checkOutput("read_opv", 32'(operands_valid), 32'(i == RL - 1));
      checkOutput("read_ctl", 32'({req_ready, busy, en_write, done, err}), 32'b01000);
      randomJunk();
      flush = (i == flush_read);
      @(negedge clk);
      flush = 1'b0;
      if (i == flush_read) return;
    end
    if (src == 2'd3) begin
      exp_err = 1'b1;
      return;
    end
    if (!wen || rd == 5'd0) begin
      exp_done = 1'b1;
      return;
    end
    if (src != 2'd1) begin
      for (int w = 0; w < TO; w++) begin
        checkOutput("wait_addr_rd", 32'(address_rd), 32'(rd));
        checkOutput("wait_src", 32'(data_in_control), 32'(src));
        checkOutput("wait_ctl", 32'({req_ready, busy, en_read_1, en_read_2, en_write, operands_valid, done, err}), 32'b01000000);
        randomJunk();
        wb_data_ready = (w == ready_delay);
        flush = (w == flush_wait);
        @(negedge clk);
        flush = 1'b0;
        if (w == flush_wait) return;
        if (w == ready_delay) break;
        if (w == TO - 1) begin
          exp_err = 1'b1;
          return;
        end
      end
    end
    checkOutput("write_en", 32'(en_write), 32'd1);
    checkOutput("write_addr_rd", 32'(address_rd), 32'(rd));
    checkOutput("write_src", 32'(data_in_control), 32'(src));
    checkOutput("write_ctl", 32'({req_ready, busy, en_read_1, en_read_2, done, err}), 32'b010010);
    randomJunk();
    flush = flush_write;
    @(negedge clk);
    flush = 1'b0;
  endtask

  initial begin
    nRst = 1'b0; flush = 1'b0; req_valid = 1'b0; wb_data_ready = 1'b0;
    req_rs1 = '0; req_rs2 = '0; req_rd = '0; req_use_rs1 = 1'b0; req_use_rs2 = 1'b0;
    req_wb_en = 1'b0; req_wb_src = '0;
    #2;
    checkIdle();
    @(negedge clk);
    nRst = 1'b1;

    applyStimulus(5'd5, 5'd18, 5'd3, 1'b1, 1'b1, 1'b0, 2'd2, 0, -1, -1, 1'b0);
    applyStimulus(5'd1, 5'd2, 5'd13, 1'b1, 1'b0, 1'b1, 2'd0, 3, -1, -1, 1'b0);
    applyStimulus(5'd0, 5'd7, 5'd5, 1'b0, 1'b1, 1'b1, 2'd1, 0, -1, -1, 1'b0);
    applyStimulus(5'd4, 5'd6, 5'd0, 1'b1, 1'b1, 1'b1, 2'd2, 0, -1, -1, 1'b0);
    applyStimulus(5'd8, 5'd9, 5'd7, 1'b1, 1'b1, 1'b1, 2'd2, 99, -1, -1, 1'b0);
    applyStimulus(5'd3, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 2'd3, 0, -1, -1, 1'b0);
    applyStimulus(5'd2, 5'd2, 5'd9, 1'b0, 1'b0, 1'b1, 2'd2, 5, -1, 2, 1'b0);
    applyStimulus(5'd2, 5'd2, 5'd9, 1'b0, 1'b0, 1'b1, 2'd0, 4, -1, 4, 1'b0);
    applyStimulus(5'd2, 5'd2, 5'd9, 1'b0, 1'b0, 1'b1, 2'd2, TO - 1, -1, -1, 1'b0);
    applyStimulus(5'd2, 5'd2, 5'd11, 1'b1, 1'b0, 1'b1, 2'd0, 1, -1, -1, 1'b1);
    applyStimulus(5'd2, 5'd2, 5'd11, 1'b1, 1'b0, 1'b1, 2'd1, 0, RL - 1, -1, 1'b0);

    for (int n = 0; n < 80; n++) begin
      applyStimulus(5'($urandom), 5'($urandom), 5'($urandom % 8), 1'($urandom), 1'($urandom),
                    ($urandom % 4) != 0, 2'($urandom), int'($urandom_range(0, TO + 3)),
                    (($urandom % 8) == 0) ? int'($urandom_range(0, RL - 1)) : -1,
                    (($urandom % 8) == 0) ? int'($urandom_range(0, TO - 1)) : -1,
                    1'($urandom));
    end

    checkIdle();
    req_valid = 1'b1; req_rd = 5'd3; req_wb_en = 1'b1; req_wb_src = 2'd1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (RL) @(negedge clk);
    checkOutput("rst_pre_write", 32'(en_write), 32'd1);
    nRst = 1'b0;
    #1;
    checkOutput("rst_write", 32'({en_write, done, err, busy, en_read_1, en_read_2, operands_valid}), 32'd0);
    checkOutput("rst_addr", 32'({address_r1, address_r2, address_rd, data_in_control}), 32'd0);
    checkOutput("rst_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    nRst = 1'b1;
    checkIdle();
    @(negedge clk);
    checkIdle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/t08_regfile_sequencer.md
Name: t08_regfile_sequencer

Overview:
- Multi-cycle access controller for the t08 32x32 register file.
- Accepts one decoded-instruction request at a time and drives the register file's read addresses and enables for a fixed read latency.
- Waits for the writeback source (memory, instruction fetch, ALU) to become valid, then issues a single write cycle with the correct data-source select.
- Sits between the decoder/control unit and t08_registers; the ALU and memory interface supply the data-ready strobe.

Parameters:
READ_LAT, 1, cycles en_read_* held before operands are valid (1..7)
WB_TIMEOUT, 16, max cycles waited in WAIT_RES before aborting (1..255)

Ports:
clk  in  1  system clock, rising edge
nRst  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept a request (IDLE only)
req_rs1  in  5  source register 1 address
req_rs2  in  5  source register 2 address
req_rd  in  5  destination register address
req_use_rs1  in  1  read rs1
req_use_rs2  in  1  read rs2
req_wb_en  in  1  instruction writes rd
req_wb_src  in  2  0=memory, 1=instruction fetch (PC+4), 2=ALU, 3=illegal
wb_data_ready  in  1  selected writeback data is valid this cycle
flush  in  1  abort current operation
address_r1  out  5  to register file
address_r2  out  5  to register file
address_rd  out  5  to register file
en_read_1  out  1  to register file
en_read_2  out  1  to register file
en_write  out  1  to register file
data_in_control  out  2  to register file source mux
operands_valid  out  1  one-cycle pulse: read data valid
done  out  1  one-cycle pulse: operation retired
err  out  1  one-cycle pulse: timeout or illegal source
busy  out  1  state != IDLE

Behaviour:
- States: IDLE, READ, WAIT_RES, WRITE. Outputs are Moore-decoded from the state plus the captured request registers.
- Reset (async, nRst=0): state=IDLE, captured fields=0, counters=0.
  - All outputs 0 except req_ready=1.
  - Reset mid-operation abandons it immediately; no write is issued.
- IDLE:
  - req_ready=1; address/enable/control outputs are 0.
  - On a posedge with req_valid=1, capture rs1, rs2, rd, use flags, wb_en and wb_src, then go to READ.
- READ:
  - address_r1=rs1, address_r2=rs2, en_read_1=use_rs1, en_read_2=use_rs2. The address outputs are driven even when the corresponding enable is 0.
  - Stays READ_LAT cycles; operands_valid=1 in the last READ cycle only.
  - Exit:
    - If wb_src=3: err pulse on the next cycle, go to IDLE.
    - Else if wb_en=0 or rd=0: go to IDLE with a done pulse on that next cycle. Writes to x0 are never issued.
    - Else if wb_src=1: go to WRITE (PC data is always ready).
    - Else: go to WAIT_RES.
- WAIT_RES:
  - Enables are 0; address_rd=rd, data_in_control=wb_src.
  - wb_data_ready=1 at a posedge moves to WRITE.
  - A cycle counter starts at 0 on entry. If WB_TIMEOUT cycles elapse without ready, err pulses for 1 cycle and the state returns to IDLE with no write.
- WRITE:
  - Exactly one cycle: en_write=1, address_rd=rd, data_in_control=wb_src, done=1.
  - Always goes to IDLE next.
- IDLE and handshake timing:
  - done/err pulses for IDLE-bound exits are registered and appear in the first IDLE cycle. That IDLE cycle can also accept a new request.
  - Minimum one IDLE cycle between operations; req_ready is never 1 outside IDLE.
- flush:
  - Sampled at posedge in READ or WAIT_RES: go to IDLE, no write, no done, no err.
  - Ignored in IDLE.
  - In WRITE the write still completes (done still pulses).
  - flush has priority over wb_data_ready and timeout in the same cycle.
- Simultaneous wb_data_ready and timeout expiry in the same cycle: ready wins, go to WRITE.
- Counters:
  - Read counter is 3 bits; timeout counter is 8 bits, saturating.
  - Both clear on every state entry.

Test Plan:
- Reset, then request rs1=5, rs2=18, use both, wb_en=0 (READ_LAT=1) -> 1 READ cycle with en_read_1=en_read_2=1, address_r1=5, address_r2=18, operands_valid=1; next cycle IDLE, done=1, en_write never 1.
- Request rd=13, wb_src=0; wb_data_ready asserted 3 cycles after WAIT_RES entry -> one WRITE cycle with en_write=1, address_rd=13, data_in_control=0; a following read request for rs1=13 through t08_registers returns the memory data 345.
- Request rd=5, wb_src=1 -> READ then WRITE directly (no WAIT_RES), data_in_control=1; a later read of register 5 returns 1024.
- Request rd=0, wb_src=2, wb_data_ready held high -> no en_write ever; done pulses after READ.
- Request rd=7, wb_src=2, wb_data_ready never asserted (WB_TIMEOUT=16) -> after 16 WAIT_RES cycles err=1 for 1 cycle, IDLE, no write. Separately, wb_src=3 -> err after READ.
- Assert flush during WAIT_RES (rd=9) -> IDLE next cycle, no write/done/err. Separately, nRst low during WRITE -> all outputs 0 immediately.
